// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, default latencies and the control-output bundles.
package pipeline_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StMemWait = 2'd2,
    StErr     = 2'd3
  } hz_state_e;

  localparam int unsigned DefaultLoadLat = 1;
  localparam int unsigned DefaultWaitMax = 15;

  typedef struct packed {
    logic en_pc;
    logic en_ifid;
    logic en_idex;
    logic en_exmem;
    logic flush_ifid;
    logic bubble_idex;
  } ctrl_t;

  localparam ctrl_t CtrlRun = '{
    en_pc: 1'b1, en_ifid: 1'b1, en_idex: 1'b1, en_exmem: 1'b1,
    flush_ifid: 1'b0, bubble_idex: 1'b0
  };

  // Taken branch: keep fetching the target, squash the wrong-path instructions.
  localparam ctrl_t CtrlFlush = '{
    en_pc: 1'b1, en_ifid: 1'b1, en_idex: 1'b1, en_exmem: 1'b1,
    flush_ifid: 1'b1, bubble_idex: 1'b1
  };

  // Load-use: hold PC and IF/ID, let the load advance and inject a bubble behind it.
  localparam ctrl_t CtrlLoadUse = '{
    en_pc: 1'b0, en_ifid: 1'b0, en_idex: 1'b1, en_exmem: 1'b1,
    flush_ifid: 1'b0, bubble_idex: 1'b1
  };

  localparam ctrl_t CtrlFreeze = '{
    en_pc: 1'b0, en_ifid: 1'b0, en_idex: 1'b0, en_exmem: 1'b0,
    flush_ifid: 1'b0, bubble_idex: 1'b0
  };

  localparam ctrl_t CtrlReset = '{
    en_pc: 1'b0, en_ifid: 1'b0, en_idex: 1'b0, en_exmem: 1'b0,
    flush_ifid: 1'b1, bubble_idex: 1'b1
  };

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection between the load in EX and the instruction in ID.
module hazard_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       hz
);

  // $zero never carries a real dependency.
  always_comb begin
    hz = ex_mem_read && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait freezes
// with a timeout trap, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned LOAD_LAT = DefaultLoadLat,
  parameter int unsigned WAIT_MAX = DefaultWaitMax
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        enPC,
  output logic        enIFID,
  output logic        enIDEX,
  output logic        enEXMEM,
  output logic        flushIFID,
  output logic        bubbleIDEX,
  output logic [15:0] stall_cnt,
  output logic        timeout_err
);

  localparam logic [1:0] LuLast         = 2'(LOAD_LAT - 1);
  localparam logic [7:0] WaitLast       = 8'(WAIT_MAX);
  localparam bit         MultiCycleLoad = (LOAD_LAT > 1);

  logic        hz;
  logic        mem_pending;
  ctrl_t       ctrl;
  hz_state_e   state_q, state_d;
  logic [1:0]  lu_cnt_q, lu_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        timeout_err_q, timeout_err_d;

  hazard_detect u_hazard_detect (
    .ex_mem_read (ex_MemRead),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .hz          (hz)
  );

  assign mem_pending = mem_req & ~mem_ack;

  always_comb begin
    state_d       = state_q;
    lu_cnt_d      = lu_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    ctrl          = CtrlRun;

    unique case (state_q)
      StRun: begin
        if (mem_pending) begin
          ctrl       = CtrlFreeze;
          state_d    = StMemWait;
          wait_cnt_d = 8'd1;
        end else if (ex_branch_taken) begin
          // The load behind a taken branch is on the wrong path, so hz is moot.
          ctrl = CtrlFlush;
        end else if (hz) begin
          ctrl = CtrlLoadUse;
          if (MultiCycleLoad) begin
            state_d  = StLuStall;
            lu_cnt_d = 2'd1;
          end
        end
      end
      StLuStall: begin
        if (mem_pending) begin
          ctrl       = CtrlFreeze;
          state_d    = StMemWait;
          wait_cnt_d = 8'd1;
          lu_cnt_d   = 2'd0;
        end else begin
          ctrl = CtrlLoadUse;
          if (lu_cnt_q == LuLast) begin
            state_d  = StRun;
            lu_cnt_d = 2'd0;
          end else begin
            lu_cnt_d = lu_cnt_q + 2'd1;
          end
        end
      end
      StMemWait: begin
        // A branch seen here stays latched in the frozen EX stage and is handled in RUN.
        ctrl = CtrlFreeze;
        if (mem_ack) begin
          state_d = StRun;
        end else if (wait_cnt_q == WaitLast) begin
          state_d       = StErr;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StErr: begin
        ctrl          = CtrlFreeze;
        timeout_err_d = 1'b1;
      end
    endcase

    if (!rst) begin
      ctrl = CtrlReset;
    end

    stall_cnt_d = stall_cnt_q;
    if (!ctrl.en_pc && (state_q != StErr) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StRun;
      lu_cnt_q      <= 2'd0;
      wait_cnt_q    <= 8'd0;
      stall_cnt_q   <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lu_cnt_q      <= lu_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign enPC        = ctrl.en_pc;
  assign enIFID      = ctrl.en_ifid;
  assign enIDEX      = ctrl.en_idex;
  assign enEXMEM     = ctrl.en_exmem;
  assign flushIFID   = ctrl.flush_ifid;
  assign bubbleIDEX  = ctrl.bubble_idex;
  assign stall_cnt   = stall_cnt_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: one instance with LOAD_LAT=1 and one with LOAD_LAT=3,
// driven by shared inputs.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_MemRead, ex_branch_taken, mem_req, mem_ack;

  logic        enPC1, enIFID1, enIDEX1, enEXMEM1, flush1, bubble1, tmo1;
  logic [15:0] scnt1;
  logic        enPC3, enIFID3, enIDEX3, enEXMEM3, flush3, bubble3, tmo3;
  logic [15:0] scnt3;
  logic [3:0]  en1, en3;

  int checks   = 0;
  int failures = 0;

  assign en1 = {enPC1, enIFID1, enIDEX1, enEXMEM1};
  assign en3 = {enPC3, enIFID3, enIDEX3, enEXMEM3};

  pipeline_hazard_ctrl #(.LOAD_LAT(1), .WAIT_MAX(15)) dut1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .enPC(enPC1), .enIFID(enIFID1), .enIDEX(enIDEX1),
    .enEXMEM(enEXMEM1), .flushIFID(flush1), .bubbleIDEX(bubble1), .stall_cnt(scnt1),
    .timeout_err(tmo1)
  );

  pipeline_hazard_ctrl #(.LOAD_LAT(3), .WAIT_MAX(15)) dut3 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .enPC(enPC3), .enIFID(enIFID3), .enIDEX(enIDEX3),
    .enEXMEM(enEXMEM3), .flushIFID(flush3), .bubbleIDEX(bubble3), .stall_cnt(scnt3),
    .timeout_err(tmo3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_MemRead = 1'b0; ex_rt = 5'd0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic lw_hazard();
    // lw $5 in EX, add $6,$5,$7 in ID
    ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd7; id_uses_rt = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    cyc(); #1;
    chk("rst_en", 16'(en1), 16'h0);
    chk("rst_flush", 16'(flush1), 16'h1);
    chk("rst_bubble", 16'(bubble1), 16'h1);
    chk("rst_scnt", scnt1, 16'h0);
    chk("rst_tmo", 16'(tmo1), 16'h0);

    cyc(); rst = 1'b1; #1;
    chk("run_en", 16'(en1), 16'hF);
    chk("run_flush", 16'(flush1), 16'h0);

    // Load-use, LOAD_LAT=1 vs 3
    cyc(); lw_hazard(); #1;
    chk("lu1_en", 16'(en1), 16'h3);
    chk("lu1_bubble", 16'(bubble1), 16'h1);
    chk("lu1_flush", 16'(flush1), 16'h0);
    chk("lu3_en_c1", 16'(en3), 16'h3);
    cyc(); idle(); #1;
    chk("lu1_after_en", 16'(en1), 16'hF);
    chk("lu1_after_bubble", 16'(bubble1), 16'h0);
    chk("lu1_scnt", scnt1, 16'd1);
    chk("lu3_en_c2", 16'(en3), 16'h3);
    cyc(); #1;
    chk("lu3_en_c3", 16'(en3), 16'h3);
    chk("lu3_bubble_c3", 16'(bubble3), 16'h1);
    cyc(); #1;
    chk("lu3_en_done", 16'(en3), 16'hF);
    chk("lu3_scnt", scnt3, 16'd3);

    // Load into $zero is never a hazard
    cyc(); ex_MemRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1; #1;
    chk("zero_en", 16'(en1), 16'hF);
    chk("zero_bubble", 16'(bubble1), 16'h0);
    // rt match only counts when ID reads rt
    cyc(); ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0; #1;
    chk("rt_unused_en", 16'(en1), 16'hF);
    chk("zero_scnt", scnt1, 16'd1);
    cyc(); id_uses_rt = 1'b1; #1;
    chk("rt_used_en", 16'(en1), 16'h3);
    cyc(); idle(); #1;
    chk("rt_used_scnt", scnt1, 16'd2);
    cyc(); #1;
    cyc(); #1;

    // Taken branch wins over a simultaneous load-use
    cyc(); lw_hazard(); ex_branch_taken = 1'b1; #1;
    chk("br_en", 16'(en1), 16'hF);
    chk("br_flush", 16'(flush1), 16'h1);
    chk("br_bubble", 16'(bubble1), 16'h1);
    chk("br3_en", 16'(en3), 16'hF);
    cyc(); idle(); #1;
    chk("br_after_en", 16'(en1), 16'hF);
    chk("br_after_bubble", 16'(bubble1), 16'h0);
    chk("br3_no_lustall", 16'(en3), 16'hF);
    chk("br_scnt", scnt1, 16'd2);

    cyc(); rst = 1'b0; #1;
    cyc(); rst = 1'b1; #1;
    chk("rst2_scnt", scnt1, 16'd0);

    // Memory access outstanding for three cycles; ack arrives in the third
    cyc(); mem_req = 1'b1; mem_ack = 1'b0; #1;
    chk("mw_en_c1", 16'(en1), 16'h0);
    cyc(); ex_branch_taken = 1'b1; #1;
    chk("mw_en_c2", 16'(en1), 16'h0);
    chk("mw_flush_c2", 16'(flush1), 16'h0);
    chk("mw_bubble_c2", 16'(bubble1), 16'h0);
    cyc(); mem_ack = 1'b1; #1;
    chk("mw_en_c3", 16'(en1), 16'h0);
    cyc(); mem_req = 1'b0; mem_ack = 1'b0; #1;
    chk("mw_release_en", 16'(en1), 16'hF);
    chk("mw_held_branch", 16'(flush1), 16'h1);
    chk("mw_scnt", scnt1, 16'd3);
    cyc(); idle(); #1;
    chk("mw_after_flush", 16'(flush1), 16'h0);

    cyc(); rst = 1'b0; #1;
    cyc(); rst = 1'b1; #1;

    // Memory never acknowledges: RUN cycle plus 15 MEM_WAIT cycles, then ERR
    for (int i = 0; i < 16; i++) begin
      cyc(); mem_req = 1'b1; mem_ack = 1'b0; #1;
      chk("to_en_wait", 16'(en1), 16'h0);
      chk("to_tmo_early", 16'(tmo1), 16'h0);
    end
    cyc(); #1;
    chk("to_tmo", 16'(tmo1), 16'h1);
    chk("to_err_en", 16'(en1), 16'h0);
    chk("to_scnt", scnt1, 16'd16);
    cyc(); mem_req = 1'b0; mem_ack = 1'b1; #1;
    chk("err_sticky_tmo", 16'(tmo1), 16'h1);
    chk("err_sticky_en", 16'(en1), 16'h0);
    chk("err_scnt_frozen", scnt1, 16'd16);
    cyc(); idle(); rst = 1'b0; #1;
    chk("err_rst_flush", 16'(flush1), 16'h1);
    cyc(); rst = 1'b1; #1;
    chk("err_clr_tmo", 16'(tmo1), 16'h0);
    chk("err_clr_en", 16'(en1), 16'hF);
    chk("err_clr_scnt", scnt1, 16'd0);

    // LOAD_LAT=3, reset lands on the second stall cycle
    cyc(); lw_hazard(); #1;
    chk("lr3_en_c1", 16'(en3), 16'h3);
    chk("lr3_bubble_c1", 16'(bubble3), 16'h1);
    cyc(); idle(); rst = 1'b0; #1;
    chk("lr3_rst_en", 16'(en3), 16'h0);
    chk("lr3_rst_flush", 16'(flush3), 16'h1);
    chk("lr3_rst_bubble", 16'(bubble3), 16'h1);
    cyc(); rst = 1'b1; #1;
    chk("lr3_rel_en", 16'(en3), 16'hF);
    chk("lr3_rel_bubble", 16'(bubble3), 16'h0);
    chk("lr3_rel_scnt", scnt3, 16'd0);
    cyc(); #1;
    chk("lr3_no_residual", 16'(en3), 16'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
